// File: rtl/uart_rx_fsm_if.sv
// uart_rx_fsm_if: line input, checker results and frame-control outputs of the UART receive FSM.
interface uart_rx_fsm_if;
    logic       RX_IN;
    logic       PAR_EN;
    logic [4:0] Prescale;
    logic       strt_glitch;
    logic       par_err;
    logic       stp_err;
    logic [4:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       dat_samp_en;
    logic       deser_en;
    logic       strt_chk_en;
    logic       par_chk_en;
    logic       stp_chk_en;
    logic       data_valid;

    modport master (
        output RX_IN, PAR_EN, Prescale, strt_glitch, par_err, stp_err,
        input  edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid
    );

    modport slave (
        input  RX_IN, PAR_EN, Prescale, strt_glitch, par_err, stp_err,
        output edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid
    );
endinterface

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: UART receive frame controller; owns edge/bit counters and sequences the RX checkers.
module uart_rx_fsm #(
    parameter int DATA_WIDTH = 8
) (
    input  logic         uart_rx_fsm_clk,
    input  logic         uart_rx_fsm_rst,
    uart_rx_fsm_if.slave bus
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, ERR_CHK} state_t;

    state_t     r_state;
    state_t     w_next;
    logic [4:0] r_edge_cnt;
    logic [4:0] r_prescale_l;
    logic [3:0] r_bit_cnt;
    logic       r_par_en_l;
    logic       r_data_valid;
    logic [4:0] r_en;
    logic       w_last;

    assign w_last = r_edge_cnt == r_prescale_l - 5'd1;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = bus.RX_IN ? IDLE : START;
            START:   if (w_last) w_next = bus.strt_glitch ? IDLE : DATA;
            DATA:    if (w_last && r_bit_cnt == 4'(DATA_WIDTH)) w_next = r_par_en_l ? PARITY : STOP;
            PARITY:  if (w_last) w_next = STOP;
            STOP:    if (w_last) w_next = ERR_CHK;
            default: w_next = bus.RX_IN ? IDLE : START;
        endcase
    end

    // enables are decoded from the next state so they line up with r_state
    always_ff @(posedge uart_rx_fsm_clk) begin
        if (!uart_rx_fsm_rst) begin
            r_state      <= IDLE;
            r_edge_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_prescale_l <= 5'd8;
            r_par_en_l   <= 1'b0;
            r_data_valid <= 1'b0;
            r_en         <= '0;
        end else begin
            r_state      <= w_next;
            r_data_valid <= r_state == ERR_CHK && !bus.stp_err && !(r_par_en_l && bus.par_err);
            r_en         <= w_next == START  ? 5'b10100 :
                            w_next == DATA   ? 5'b11000 :
                            w_next == PARITY ? 5'b10010 :
                            w_next == STOP   ? 5'b10001 : 5'b00000;
            if (w_next == START && r_state != START) begin
                r_prescale_l <= bus.Prescale;
                r_par_en_l   <= bus.PAR_EN;
            end
            if (w_next == IDLE) begin
                r_edge_cnt <= '0;
                r_bit_cnt  <= '0;
            end else if (w_last) begin
                r_edge_cnt <= '0;
                r_bit_cnt  <= r_state == STOP ? 4'd0 : r_bit_cnt + 4'd1;
            end else begin
                r_edge_cnt <= r_edge_cnt + 5'd1;
            end
        end
    end

    assign bus.edge_cnt    = r_edge_cnt;
    assign bus.bit_cnt     = r_bit_cnt;
    assign bus.dat_samp_en = r_en[4];
    assign bus.deser_en    = r_en[3];
    assign bus.strt_chk_en = r_en[2];
    assign bus.par_chk_en  = r_en[1];
    assign bus.stp_chk_en  = r_en[0];
    assign bus.data_valid  = r_data_valid;
endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb_uart_rx_fsm: directed frames against uart_rx_fsm with hand-computed timing and counter values.
module tb_uart_rx_fsm;
    logic clk = 1'b0;
    logic rst_l = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    int dv_cnt, dv_at0, dv_at1;
    int ds_cnt, ds_min, ds_max;
    int par_cnt, par_min, par_max;
    int stp_cnt, stp_min, stp_max;
    logic [31:0] snap_edge, snap_bit, snap_en;

    localparam logic [4:0] EN_START = 5'b10100;

    uart_rx_fsm_if bus();

    uart_rx_fsm #(.DATA_WIDTH(8)) dut (
        .uart_rx_fsm_clk(clk),
        .uart_rx_fsm_rst(rst_l),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] en_bits();
        return {bus.dat_samp_en, bus.deser_en, bus.strt_chk_en, bus.par_chk_en, bus.stp_chk_en};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // iteration n drives the cycle whose closing edge is detection edge + n, then observes its result
    task automatic run(input int p, input bit pe, input logic [31:0] line, input int unit, input int cycles,
                       input int glitch_n, input int snap_n, input int rst_at, input int chg_at,
                       input bit perr, input bit serr);
        bus.RX_IN = 1'b1;
        bus.strt_glitch = 1'b0;
        rst_l = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        dv_cnt = 0; dv_at0 = -1; dv_at1 = -1;
        ds_cnt = 0; ds_min = 99; ds_max = -1;
        par_cnt = 0; par_min = 99; par_max = -1;
        stp_cnt = 0; stp_min = 99; stp_max = -1;
        snap_edge = 'x; snap_bit = 'x; snap_en = 'x;
        bus.Prescale = 5'(p);
        bus.PAR_EN = pe;
        bus.par_err = perr;
        bus.stp_err = serr;
        for (int n = 0; n < cycles; n++) begin
            bus.RX_IN = (n / unit < 32) ? line[n / unit] : 1'b1;
            bus.strt_glitch = (n == glitch_n);
            rst_l = (n != rst_at);
            if (n == chg_at) bus.Prescale = 5'd16;
            @(posedge clk);
            #1;
            if (bus.data_valid) begin
                dv_cnt++;
                if (dv_cnt == 1) dv_at0 = n; else dv_at1 = n;
            end
            if (bus.deser_en) begin
                ds_cnt++;
                ds_min = (int'(bus.bit_cnt) < ds_min) ? int'(bus.bit_cnt) : ds_min;
                ds_max = (int'(bus.bit_cnt) > ds_max) ? int'(bus.bit_cnt) : ds_max;
            end
            if (bus.par_chk_en) begin
                par_cnt++;
                par_min = (int'(bus.bit_cnt) < par_min) ? int'(bus.bit_cnt) : par_min;
                par_max = (int'(bus.bit_cnt) > par_max) ? int'(bus.bit_cnt) : par_max;
            end
            if (bus.stp_chk_en) begin
                stp_cnt++;
                stp_min = (int'(bus.bit_cnt) < stp_min) ? int'(bus.bit_cnt) : stp_min;
                stp_max = (int'(bus.bit_cnt) > stp_max) ? int'(bus.bit_cnt) : stp_max;
            end
            if (n == snap_n) begin
                snap_edge = 32'(bus.edge_cnt);
                snap_bit  = 32'(bus.bit_cnt);
                snap_en   = 32'(en_bits());
            end
        end
        rst_l = 1'b1;
        bus.strt_glitch = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_edge"}, 32'(bus.edge_cnt), 0);
        check({tag, "_bit"}, 32'(bus.bit_cnt), 0);
        check({tag, "_en"}, 32'(en_bits()), 0);
        check({tag, "_dv"}, 32'(bus.data_valid), 0);
    endtask

    initial begin
        bus.RX_IN = 1'b1;
        bus.PAR_EN = 1'b0;
        bus.Prescale = 5'd8;
        bus.strt_glitch = 1'b0;
        bus.par_err = 1'b0;
        bus.stp_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");

        // 0xA5, Prescale 8, no parity: ERR_CHK after 80 cycles, data_valid one edge later
        run(8, 0, {22'h3FFFFF, 1'b1, 8'hA5, 1'b0}, 8, 90, -1, 0, -1, -1, 0, 0);
        check("a5_snap_edge", snap_edge, 1);
        check("a5_snap_bit", snap_bit, 0);
        check("a5_snap_en", snap_en, 32'(EN_START));
        check("a5_dv_cnt", dv_cnt, 1);
        check("a5_dv_at", dv_at0, 80);
        check("a5_ds_cnt", ds_cnt, 64);
        check("a5_ds_min", ds_min, 1);
        check("a5_ds_max", ds_max, 8);
        check("a5_par_cnt", par_cnt, 0);
        check("a5_stp_cnt", stp_cnt, 8);
        check("a5_stp_bit", stp_max, 9);

        // 0x3C, Prescale 16, even parity bit 0
        run(16, 1, {21'h1FFFFF, 1'b1, 1'b0, 8'h3C, 1'b0}, 16, 190, -1, -1, -1, -1, 0, 0);
        check("p16_dv_cnt", dv_cnt, 1);
        check("p16_dv_at", dv_at0, 176);
        check("p16_par_cnt", par_cnt, 16);
        check("p16_par_min", par_min, 9);
        check("p16_par_max", par_max, 9);
        check("p16_stp_min", stp_min, 10);
        check("p16_stp_max", stp_max, 10);
        check("p16_ds_max", ds_max, 8);

        // three-cycle low glitch rejected at the last START edge
        run(8, 0, 32'hFFFF_FFF8, 1, 20, 7, 7, -1, -1, 0, 0);
        check("glitch_snap_edge", snap_edge, 0);
        check("glitch_snap_bit", snap_bit, 0);
        check("glitch_snap_en", snap_en, 0);
        check("glitch_ds_cnt", ds_cnt, 0);
        check("glitch_dv_cnt", dv_cnt, 0);
        check_idle("glitch_end");

        // back-to-back frames: start bit of frame 2 falls in the ERR_CHK cycle
        run(8, 0, {12'hFFF, 1'b1, 8'h5A, 1'b0, 1'b1, 8'hA5, 1'b0}, 8, 170, -1, 80, -1, -1, 0, 0);
        check("b2b_dv_cnt", dv_cnt, 2);
        check("b2b_dv_at0", dv_at0, 80);
        check("b2b_dv_at1", dv_at1, 160);
        check("b2b_snap_en", snap_en, 32'(EN_START));
        check("b2b_snap_edge", snap_edge, 1);
        check("b2b_ds_cnt", ds_cnt, 128);

        // stop error: ERR_CHK reached, no data_valid
        run(8, 0, {22'h3FFFFF, 1'b1, 8'h0F, 1'b0}, 8, 90, -1, -1, -1, -1, 0, 1);
        check("stp_dv_cnt", dv_cnt, 0);
        check("stp_stp_cnt", stp_cnt, 8);
        check_idle("stp_end");

        // parity error with parity enabled
        run(8, 1, {21'h1FFFFF, 1'b1, 1'b1, 8'h01, 1'b0}, 8, 100, -1, -1, -1, -1, 1, 0);
        check("perr_dv_cnt", dv_cnt, 0);
        check("perr_par_cnt", par_cnt, 8);
        check_idle("perr_end");

        // parity error ignored when the frame has no parity bit
        run(8, 0, {22'h3FFFFF, 1'b1, 8'hA5, 1'b0}, 8, 90, -1, -1, -1, -1, 1, 0);
        check("perr_off_dv_cnt", dv_cnt, 1);
        check("perr_off_dv_at", dv_at0, 80);

        // reset asserted mid-DATA
        run(8, 0, 32'hFFFF_FFFE, 8, 100, -1, 30, 30, -1, 0, 0);
        check("rst_snap_edge", snap_edge, 0);
        check("rst_snap_bit", snap_bit, 0);
        check("rst_snap_en", snap_en, 0);
        check("rst_dv_cnt", dv_cnt, 0);

        // Prescale changed mid-frame: latched 8 still governs
        run(8, 0, {22'h3FFFFF, 1'b1, 8'hA5, 1'b0}, 8, 90, -1, -1, -1, 20, 0, 0);
        check("chg_dv_cnt", dv_cnt, 1);
        check("chg_dv_at", dv_at0, 80);
        check("chg_ds_cnt", ds_cnt, 64);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
